// File: rtl/pwm_capture.sv
// Three-channel PWM decoder: per-channel high time (8b, saturated) and period.
// Optional glitch filter after the synchroniser: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       pwm_in,
    output logic [7:0]       value_output0,
    output logic [7:0]       value_output1,
    output logic [7:0]       value_output2,
    output logic [CNT_W-1:0] period_output0,
    output logic [CNT_W-1:0] period_output1,
    output logic [CNT_W-1:0] period_output2,
    output logic [2:0]       valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAT8    = CNT_W'(255);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] s;
    logic [2:0] d;
    logic [2:0] rise_q;

    logic [2:0]            armed;
    logic [2:0][CNT_W-1:0] hi_cnt;
    logic [2:0][CNT_W-1:0] per_cnt;
    logic [2:0][7:0]       value_r;
    logic [2:0][CNT_W-1:0] period_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [2:0] h1;
    logic [2:0] h2;
    logic [2:0] filt_q;
    logic [2:0] agree;

    // Level only moves once three consecutive samples agree.
    assign agree = ~(sync2 ^ h1) & ~(h1 ^ h2);
    assign s     = (agree & sync2) | (~agree & filt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            h1     <= '0;
            h2     <= '0;
            filt_q <= '0;
        end else begin
            h1     <= sync2;
            h2     <= h1;
            filt_q <= s;
        end
    end
`else
    assign s = sync2;
`endif

    // d doubles as the level aligned with rise_q for high-time counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            d      <= '0;
            rise_q <= '0;
        end else begin
            d      <= s;
            rise_q <= s & ~d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed    <= '0;
            hi_cnt   <= '0;
            per_cnt  <= '0;
            value_r  <= '0;
            period_r <= '0;
            valid    <= '0;
        end else begin
            valid <= '0;
            for (int i = 0; i < 3; i++) begin
                if (!en) begin
                    armed[i]   <= 1'b0;
                    hi_cnt[i]  <= '0;
                    per_cnt[i] <= '0;
                end else if (rise_q[i]) begin
                    if (armed[i]) begin
                        value_r[i]  <= (hi_cnt[i] > SAT8) ?
                                       8'hFF : hi_cnt[i][7:0];
                        period_r[i] <= per_cnt[i];
                        valid[i]    <= 1'b1;
                    end
                    armed[i]   <= 1'b1;
                    hi_cnt[i]  <= CNT_W'(1);
                    per_cnt[i] <= CNT_W'(1);
                end else if (per_cnt[i] == TO_CNT) begin
                    // Disarming here keeps a static pin to a single strobe.
                    if (armed[i]) begin
                        value_r[i]  <= d[i] ? 8'hFF : 8'h00;
                        period_r[i] <= '0;
                        valid[i]    <= 1'b1;
                    end
                    armed[i]   <= 1'b0;
                    hi_cnt[i]  <= '0;
                    per_cnt[i] <= '0;
                end else begin
                    if (per_cnt[i] != CNT_MAX)
                        per_cnt[i] <= per_cnt[i] + CNT_W'(1);
                    if (hi_cnt[i] != CNT_MAX)
                        hi_cnt[i] <= hi_cnt[i] + CNT_W'(d[i]);
                end
            end
        end
    end

    assign value_output0  = value_r[0];
    assign value_output1  = value_r[1];
    assign value_output2  = value_r[2];
    assign period_output0 = period_r[0];
    assign period_output1 = period_r[1];
    assign period_output2 = period_r[2];

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: per-cycle pin waveforms, reference built from the
// rise positions of the (optionally filtered) waveform.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       pwm_in;
    logic [7:0]       value_output0;
    logic [7:0]       value_output1;
    logic [7:0]       value_output2;
    logic [CNT_W-1:0] period_output0;
    logic [CNT_W-1:0] period_output1;
    logic [CNT_W-1:0] period_output2;
    logic [2:0]       valid;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .pwm_in         (pwm_in),
        .value_output0  (value_output0),
        .value_output1  (value_output1),
        .value_output2  (value_output2),
        .period_output0 (period_output0),
        .period_output1 (period_output1),
        .period_output2 (period_output2),
        .valid          (valid)
    );

    always #5 clk = ~clk;

    bit          wave [3][$];
    logic [23:0] exp_q [3][$];
    logic [23:0] got_q [3][$];
    int          checks = 0;
    int          errors = 0;
    bit          tri_phase = 1'b0;
    int          tri_cnt = 0;
    int          part_cnt = 0;

    always @(negedge clk) begin
        if (valid[0]) got_q[0].push_back({value_output0, period_output0});
        if (valid[1]) got_q[1].push_back({value_output1, period_output1});
        if (valid[2]) got_q[2].push_back({value_output2, period_output2});
        if (tri_phase) begin
            if (valid == 3'b111) tri_cnt++;
            else if (valid != 3'b000) part_cnt++;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_pwm(int c, int h, int l, int n);
        repeat (n) begin
            repeat (h) wave[c].push_back(1'b1);
            repeat (l) wave[c].push_back(1'b0);
        end
    endtask

    task automatic add_lvl(int c, bit b, int n);
        repeat (n) wave[c].push_back(b);
    endtask

    function automatic bit samp(int c, int t);
        return (t < 0) ? 1'b0 : wave[c][t];
    endfunction

    // Expected reports: one per pair of consecutive rises, the first rise
    // only arms; a gap reaching TIMEOUT-1 cycles yields one static report.
    function automatic void model(int c);
        int n = wave[c].size();
        bit f[$];
        int r[$];
        bit cur = 1'b0;
        bit prev = 1'b0;
        bit armed = 1'b0;
        for (int t = 0; t < n; t++) begin
            bit x = wave[c][t];
            if (!FILT) cur = x;
            else if (x == samp(c, t-1) && x == samp(c, t-2)) cur = x;
            f.push_back(cur);
            if (cur && !prev) r.push_back(t);
            prev = cur;
        end
        for (int k = 0; k < r.size(); k++) begin
            if (armed) begin
                int p = r[k] - r[k-1];
                if (p > TIMEOUT - 1) begin
                    int ts = r[k-1] + TIMEOUT - 1;
                    exp_q[c].push_back({f[ts] ? 8'hFF : 8'h00, 16'd0});
                end else begin
                    int ones = 0;
                    for (int t = r[k-1]; t < r[k]; t++) ones += f[t];
                    if (ones > 255) ones = 255;
                    exp_q[c].push_back({8'(ones), 16'(p)});
                end
            end
            armed = 1'b1;
        end
        if (armed && r[r.size()-1] + TIMEOUT - 1 <= n - 1) begin
            int ts = r[r.size()-1] + TIMEOUT - 1;
            exp_q[c].push_back({f[ts] ? 8'hFF : 8'h00, 16'd0});
        end
    endfunction

    task automatic play(bit do_model);
        int n = 0;
        for (int c = 0; c < 3; c++)
            if (wave[c].size() > n) n = wave[c].size();
        for (int c = 0; c < 3; c++)
            while (wave[c].size() < n) wave[c].push_back(1'b0);
        if (do_model)
            for (int c = 0; c < 3; c++) model(c);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            pwm_in = {wave[2][t], wave[1][t], wave[0][t]};
        end
        repeat (12) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) wave[c].delete();
    endtask

    task automatic compare(string tag);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s_ch%0d_count", tag, c),
                got_q[c].size(), exp_q[c].size());
            for (int k = 0; k < exp_q[c].size() && k < got_q[c].size(); k++)
                chk($sformatf("%s_ch%0d_ev%0d", tag, c, k),
                    got_q[c][k], exp_q[c][k]);
            got_q[c].delete();
            exp_q[c].delete();
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_v0"}, value_output0, 0);
        chk({tag, "_v1"}, value_output1, 0);
        chk({tag, "_v2"}, value_output2, 0);
        chk({tag, "_p0"}, period_output0, 0);
        chk({tag, "_p1"}, period_output1, 0);
        chk({tag, "_p2"}, period_output2, 0);
        chk({tag, "_valid"}, valid, 0);
    endtask

    initial begin
        logic [7:0]       sv [3];
        logic [CNT_W-1:0] sp [3];
        int h;
        int l;

        rst = 1'b1;
        en = 1'b0;
        pwm_in = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        en = 1'b1;

        // 40/128 on ch0, others idle
        add_pwm(0, 40, 88, 5);
        add_lvl(0, 1'b0, TIMEOUT + 50);
        play(1'b1);
        compare("basic");

        // ch1 static high then static low after pulse trains
        add_pwm(1, 30, 50, 3);
        add_lvl(1, 1'b1, 2 * TIMEOUT + 50);
        add_lvl(1, 1'b0, 20);
        add_pwm(1, 30, 50, 3);
        add_lvl(1, 1'b0, 2 * TIMEOUT + 50);
        play(1'b1);
        compare("timeout");

        // high time beyond 255 saturates
        add_pwm(2, 300, 100, 3);
        add_lvl(2, 1'b0, TIMEOUT + 50);
        play(1'b1);
        compare("sat");

        // reset during the low phase of a period
        add_pwm(0, 40, 88, 3);
        add_lvl(0, 1'b1, 40);
        add_lvl(0, 1'b0, 30);
        play(1'b1);
        compare("pre_rst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("mid_rst");
        add_lvl(0, 1'b0, 58);
        add_pwm(0, 40, 88, 3);
        add_lvl(0, 1'b0, TIMEOUT + 50);
        play(1'b1);
        compare("post_rst");

        // enable drop: leave channels armed with fresh outputs first
        for (int c = 0; c < 3; c++) begin
            add_pwm(c, $urandom_range(3, 200), $urandom_range(3, 200), 3);
            add_lvl(c, 1'b0, 20);
        end
        play(1'b1);
        compare("pre_en");
        sv[0] = value_output0;
        sv[1] = value_output1;
        sv[2] = value_output2;
        sp[0] = period_output0;
        sp[1] = period_output1;
        sp[2] = period_output2;
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            add_pwm(c, 10, 15, 2);
            add_lvl(c, 1'b0, 10);
        end
        play(1'b0);
        compare("en_low");
        chk("en_hold_v0", value_output0, sv[0]);
        chk("en_hold_v1", value_output1, sv[1]);
        chk("en_hold_v2", value_output2, sv[2]);
        chk("en_hold_p0", period_output0, sp[0]);
        chk("en_hold_p1", period_output1, sp[1]);
        chk("en_hold_p2", period_output2, sp[2]);
        en = 1'b1;

        // identical waveforms on all channels
        h = $urandom_range(3, 200);
        l = $urandom_range(3, 200);
        for (int c = 0; c < 3; c++) begin
            add_pwm(c, h, l, 4);
            add_lvl(c, 1'b0, TIMEOUT + 50);
        end
        tri_cnt = 0;
        part_cnt = 0;
        tri_phase = 1'b1;
        play(1'b1);
        tri_phase = 1'b0;
        chk("tri_partial", part_cnt, 0);
        chk("tri_together", tri_cnt, exp_q[0].size());
        compare("tri");

        // 1-cycle low glitch inside the high phase
        repeat (4) begin
            add_lvl(0, 1'b1, 20);
            add_lvl(0, 1'b0, 1);
            add_lvl(0, 1'b1, 19);
            add_lvl(0, 1'b0, 88);
        end
        add_lvl(0, 1'b0, TIMEOUT + 50);
        play(1'b1);
        compare("glitch");

        // period exactly TIMEOUT-1 (rise wins) and TIMEOUT (timeout wins)
        add_pwm(0, 100, TIMEOUT - 101, 3);
        add_lvl(0, 1'b0, TIMEOUT + 50);
        add_pwm(1, 100, TIMEOUT - 100, 3);
        add_lvl(1, 1'b0, TIMEOUT + 50);
        play(1'b1);
        compare("to_edge");

        // random independent channels
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int c = 0; c < 3; c++) begin
                repeat ($urandom_range(2, 5))
                    add_pwm(c, $urandom_range(3, 300),
                            $urandom_range(3, 300), 1);
                add_lvl(c, 1'b0, TIMEOUT + 50);
            end
            play(1'b1);
            compare($sformatf("rand%0d", rnd));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
